// File: rtl/sprite_fetch_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | sprite_fetch_sched: per-scanline sprite row fetch, one ROM shared by hero/monster.    |
// | Optional horizontal mirror via SPRITE_FETCH_MIRROR_EN.  Rev 1.0                       |
// +--------------------------------------------------------------------------------------+
module sprite_fetch_sched #(
   parameter int SPR_W   = 128,
   parameter int SPR_H   = 128,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 12,
   parameter int ROM_LAT = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      line_start,
   input  logic [10:0]               next_row,
   input  logic                      en0,
   input  logic                      en1,
   input  logic [10:0]               x0,
   input  logic [10:0]               x1,
   input  logic [10:0]               y0,
   input  logic [10:0]               y1,
   input  logic [ADDR_W-1:0]         base0,
   input  logic [ADDR_W-1:0]         base1,
`ifdef SPRITE_FETCH_MIRROR_EN
   input  logic                      hflip0,
   input  logic                      hflip1,
`endif
   output logic                      rom_en,
   output logic [ADDR_W-1:0]         rom_addr,
   input  logic [DATA_W-1:0]         rom_data,
   output logic                      wr_en,
   output logic                      wr_sel,
   output logic [$clog2(SPR_W)-1:0]  wr_addr,
   output logic [DATA_W-1:0]         wr_data,
   output logic                      hit0,
   output logic                      hit1,
   output logic                      busy,
   output logic                      done,
   output logic                      overrun
);

   localparam int CW = $clog2(SPR_W);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      EVAL    = 3'd1,
      FETCH_A = 3'd2,
      FETCH_B = 3'd3,
      DRAIN   = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t            state;
   logic [CW-1:0]     col;
   logic [1:0]        drain_cnt;
   logic              prio;
   logic              cur_sel;
   logic              second_pend;
   logic [11:0]       dy0_r, dy1_r;
   logic [ADDR_W-1:0] base_r;

   logic [ROM_LAT-1:0] tag_v;
   logic [ROM_LAT-1:0] tag_s;
   logic [CW-1:0]      tag_c [ROM_LAT];

   // x positions only matter to the line-buffer reader
   logic unused_x;
   assign unused_x = ^{x0, x1};

   logic [11:0] dy0, dy1;
   logic        h0, h1, hp, ho, first_sel, any_hit, both_hit;
   assign dy0 = {1'b0, next_row} - {1'b0, y0};
   assign dy1 = {1'b0, next_row} - {1'b0, y1};
   assign h0  = en0 && (next_row >= y0) && (dy0 < 12'(SPR_H));
   assign h1  = en1 && (next_row >= y1) && (dy1 < 12'(SPR_H));
   assign hp  = prio ? h1 : h0;
   assign ho  = prio ? h0 : h1;
   assign first_sel = hp ? prio : ~prio;
   assign any_hit   = hp | ho;
   assign both_hit  = hp & ho;

   logic fetching, abort, last_col;
   assign fetching = (state == FETCH_A) || (state == FETCH_B);
   assign abort    = line_start && (state != IDLE);
   assign last_col = &col;

   logic [CW-1:0] col_rom;
   logic [11:0]   dy_cur;
   assign dy_cur = cur_sel ? dy1_r : dy0_r;
`ifdef SPRITE_FETCH_MIRROR_EN
   logic flip0_r, flip1_r;
   assign col_rom = (cur_sel ? flip1_r : flip0_r) ? ~col : col;
`else
   assign col_rom = col;
`endif

   assign rom_en   = fetching;
   assign rom_addr = fetching ? (base_r + ADDR_W'({dy_cur, {CW{1'b0}}}) + ADDR_W'(col_rom))
                              : '0;
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         col         <= '0;
         drain_cnt   <= '0;
         prio        <= 1'b0;
         cur_sel     <= 1'b0;
         second_pend <= 1'b0;
         dy0_r       <= '0;
         dy1_r       <= '0;
         base_r      <= '0;
         hit0        <= 1'b0;
         hit1        <= 1'b0;
         overrun     <= 1'b0;
`ifdef SPRITE_FETCH_MIRROR_EN
         flip0_r     <= 1'b0;
         flip1_r     <= 1'b0;
`endif
      end else if (abort) begin
         overrun <= 1'b1;
         state   <= EVAL;
         if (state == DONE)
            prio <= ~prio;
      end else begin
         case (state)
            IDLE: begin
               if (line_start)
                  state <= EVAL;
            end
            EVAL: begin
               hit0        <= h0;
               hit1        <= h1;
               dy0_r       <= dy0;
               dy1_r       <= dy1;
`ifdef SPRITE_FETCH_MIRROR_EN
               flip0_r     <= hflip0;
               flip1_r     <= hflip1;
`endif
               col         <= '0;
               drain_cnt   <= '0;
               cur_sel     <= first_sel;
               second_pend <= both_hit;
               base_r      <= first_sel ? base1 : base0;
               // a miss line still passes through DRAIN so latency stays 2+n*SPR_W+ROM_LAT
               state       <= any_hit ? FETCH_A : DRAIN;
            end
            FETCH_A: begin
               col <= col + 1'b1;
               if (last_col) begin
                  if (second_pend) begin
                     state   <= FETCH_B;
                     cur_sel <= ~cur_sel;
                     base_r  <= cur_sel ? base0 : base1;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            FETCH_B: begin
               col <= col + 1'b1;
               if (last_col)
                  state <= DRAIN;
            end
            DRAIN: begin
               if (drain_cnt == 2'(ROM_LAT - 1))
                  state <= DONE;
               else
                  drain_cnt <= drain_cnt + 1'b1;
            end
            DONE: begin
               prio  <= ~prio;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // write tags travel alongside the ROM read; an abort kills every stage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_v <= '0;
         tag_s <= '0;
         for (int i = 0; i < ROM_LAT; i++)
            tag_c[i] <= '0;
      end else begin
         tag_v[0] <= fetching && !abort;
         tag_s[0] <= cur_sel;
         tag_c[0] <= col;
         for (int i = 1; i < ROM_LAT; i++) begin
            tag_v[i] <= tag_v[i-1] && !abort;
            tag_s[i] <= tag_s[i-1];
            tag_c[i] <= tag_c[i-1];
         end
      end
   end

   assign wr_en   = tag_v[ROM_LAT-1];
   assign wr_sel  = tag_s[ROM_LAT-1];
   assign wr_addr = tag_c[ROM_LAT-1];
   assign wr_data = wr_en ? rom_data : '0;

endmodule
`default_nettype wire
